// File: rtl/eje6_tdm_tx.sv
// eje6_tdm_tx: round-robin TDM transmitter feeding a 1:4 demux (d, s1:s0).
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_data[3:0]
// word handshake; d, s0, s1 serial data and slot select; busy, frame_done.
// Param DWELL (1..255) cycles per slot. Macro EJE6_CONT_EN: back-to-back
// frames, a new word may be taken in the frame_done cycle, else repeat.
module eje6_tdm_tx #(
  parameter int DWELL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  output logic       d,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    word_q, word_d;
  logic [1:0]    slot_q, slot_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic slot_end;
  logic last;
  logic accept;

  assign slot_end = (state_q == SEND) && (cnt_q == LAST);
  assign last     = slot_end && (slot_q == 2'd3);

`ifdef EJE6_CONT_EN
  assign in_ready = (state_q == IDLE) || last;
`else
  assign in_ready = (state_q == IDLE);
`endif

  assign accept = in_valid && in_ready;

  assign busy       = (state_q == SEND);
  assign s0         = busy & slot_q[0];
  assign s1         = busy & slot_q[1];
  assign d          = busy & word_q[slot_q];
  assign frame_done = last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      slot_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          word_d  = in_data;
          slot_d  = '0;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (slot_end) begin
          cnt_d  = '0;
          // slot 3 wraps to 0, which is exactly the next frame's start
          slot_d = slot_q + 2'd1;
          if (last) begin
`ifdef EJE6_CONT_EN
            if (accept) begin
              word_d = in_data;
            end
`else
            state_d = IDLE;
`endif
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_eje6_tdm_tx.sv
// tb_eje6_tdm_tx: self-checking bench for eje6_tdm_tx (DWELL=2 and 1).
// Vector table, corner sequences, random run against a queue model.
module tb_eje6_tdm_tx;

`ifdef EJE6_CONT_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif
  localparam int D2 = 2;

  logic clk;
  logic rst;
  logic vld2, vld1;
  logic [3:0] dat2, dat1;
  logic r2, d2, s02, s12, b2, f2;
  logic r1, d1, s01, s11, b1, f1;

  int total = 0;
  int bad = 0;

  eje6_tdm_tx #(.DWELL(2)) u2 (
    .clk(clk), .rst(rst),
    .in_valid(vld2), .in_ready(r2), .in_data(dat2),
    .d(d2), .s0(s02), .s1(s12),
    .busy(b2), .frame_done(f2)
  );

  eje6_tdm_tx #(.DWELL(1)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(vld1), .in_ready(r1), .in_data(dat1),
    .d(d1), .s0(s01), .s1(s11),
    .busy(b1), .frame_done(f1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // observed vector: {in_ready, busy, s1, s0, d, frame_done}
  function automatic logic [5:0] o2();
    return {r2, b2, s12, s02, d2, f2};
  endfunction

  function automatic logic [5:0] o1();
    return {r1, b1, s11, s01, d1, f1};
  endfunction

  task automatic chk(input string nm, input logic [5:0] act,
                     input logic [5:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", nm, act, exp);
    end
  endtask

  // ---------------- reference model (DWELL=2 instance) ----------------
  typedef struct packed {
    logic [1:0] sel;
    logic       d;
    logic       fd;
  } slot_t;

  slot_t mq[$];
  logic [3:0] held;

  task automatic m_push(input logic [3:0] w);
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < D2; j++)
        mq.push_back({2'(k), w[k], (k == 3 && j == D2 - 1)});
  endtask

  function automatic logic [5:0] m_out();
    if (mq.size() == 0) return 6'b100000;
    return {CONT && mq[0].fd, 1'b1, mq[0].sel, mq[0].d, mq[0].fd};
  endfunction

  task automatic m_step(input logic v, input logic [3:0] w);
    logic [5:0] e;
    logic pf;
    e = m_out();
    pf = 1'b0;
    if (mq.size() > 0) begin
      pf = mq[0].fd;
      void'(mq.pop_front());
    end
    if (v && e[5]) begin
      held = w;
      m_push(w);
    end else if (CONT && pf) begin
      m_push(held);
    end
  endtask

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    vld2 = 1'b0;
    vld1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // checks one DWELL=2 frame of word w on u2; accept is at next posedge
  task automatic frame_chk(input string nm, input logic [3:0] w,
                           input logic nv, input logic [3:0] nd);
    logic [5:0] e;
    for (int o = 0; o < 4 * D2; o++) begin
      @(negedge clk);
      e = {CONT && (o == 4 * D2 - 1), 1'b1, 2'(o / D2), w[o / D2],
           o == 4 * D2 - 1};
      chk($sformatf("%s_c%0d", nm, o), o2(), e);
      if (o == 4 * D2 - 1) begin
        vld2 = nv;
        dat2 = nd;
      end else begin
        vld2 = 1'b0;
      end
    end
  endtask

  typedef struct {
    logic       v;
    logic [3:0] dat;
    logic [5:0] exp;
  } vec_t;

  vec_t tab[10];

  initial begin
    logic [5:0] e;
    logic [3:0] w;

    rst = 1'b1;
    vld2 = 1'b0;
    vld1 = 1'b0;
    dat2 = '0;
    dat1 = '0;
    held = '0;

    // reset held
    repeat (2) @(negedge clk);
    chk("rst_hold_u2", o2(), 6'b100000);
    chk("rst_hold_u1", o1(), 6'b100000);
    rst = 1'b0;

    // single frame 0101 with ignored mid-frame valid/data
    tab[0] = '{1'b1, 4'b0101, 6'b100000};
    tab[1] = '{1'b0, 4'b0000, 6'b010010};
    tab[2] = '{1'b1, 4'b1111, 6'b010010};
    tab[3] = '{1'b0, 4'b1010, 6'b010100};
    tab[4] = '{1'b1, 4'b1111, 6'b010100};
    tab[5] = '{1'b0, 4'b0000, 6'b011010};
    tab[6] = '{1'b1, 4'b0110, 6'b011010};
    tab[7] = '{1'b0, 4'b0000, 6'b011100};
    tab[8] = '{1'b0, 4'b0000, {CONT, 5'b11101}};
    tab[9] = '{1'b0, 4'b0000, CONT ? 6'b010010 : 6'b100000};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("tab%0d", i), o2(), tab[i].exp);
      vld2 = tab[i].v;
      dat2 = tab[i].dat;
    end

    // DWELL=1 frame of 1001
    @(negedge clk);
    vld2 = 1'b0;
    vld1 = 1'b1;
    dat1 = 4'b1001;
    w = 4'b1001;
    for (int o = 0; o < 4; o++) begin
      @(negedge clk);
      e = {CONT && (o == 3), 1'b1, 2'(o), w[o], o == 3};
      chk($sformatf("dw1_c%0d", o), o1(), e);
      vld1 = 1'b0;
    end
    @(negedge clk);
    chk("dw1_after", o1(), CONT ? 6'b010010 : 6'b100000);

    // async reset during slot 2 of 1010
    do_reset();
    vld2 = 1'b1;
    dat2 = 4'b1010;
    for (int o = 0; o < 5; o++) begin
      @(negedge clk);
      vld2 = 1'b0;
    end
    chk("pre_abort", o2(), 6'b011000);
    #2 rst = 1'b1;
    #1 chk("async_rst", o2(), 6'b100000);
    @(negedge clk);
    chk("rst_still", o2(), 6'b100000);
    rst = 1'b0;
    vld2 = 1'b1;
    dat2 = 4'b0011;
    frame_chk("after_rst", 4'b0011, 1'b0, 4'b0000);

`ifdef EJE6_CONT_EN
    do_reset();
    vld2 = 1'b1;
    dat2 = 4'b0110;
    frame_chk("cont_f1", 4'b0110, 1'b0, 4'b0000);
    frame_chk("cont_f2", 4'b0110, 1'b1, 4'b1100);
    frame_chk("cont_f3", 4'b1100, 1'b0, 4'b0000);
`endif

    // random run against the model
    do_reset();
    dat2 = '0;
    mq.delete();
    held = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      chk($sformatf("rand_c%0d", c), o2(), m_out());
      vld2 = ($urandom_range(0, 3) == 0);
      dat2 = 4'($urandom);
      m_step(vld2, dat2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
